// File: rtl/sha3_pkg.sv
// Shared types and lookup tables for the SHA-3/SHAKE output stage.
package sha3_pkg;

    localparam int LANE_W  = 64;
    localparam int STATE_W = 25 * LANE_W;

    typedef enum logic [2:0] {
        SHA3_224 = 3'd0,
        SHA3_256 = 3'd1,
        SHA3_384 = 3'd2,
        SHA3_512 = 3'd3,
        SHAKE128 = 3'd4,
        SHAKE256 = 3'd5
    } mode_t;

    // Codes 6 and 7 fall back to SHA3-256.
    function automatic mode_t decode_mode(input logic [2:0] m);
        mode_t r;
        r = (m > 3'd5) ? SHA3_256 : mode_t'(m);
        return r;
    endfunction

    function automatic logic [7:0] rate_bytes(input mode_t m);
        logic [7:0] r;
        case (m)
            SHA3_224: r = 8'd144;
            SHA3_256: r = 8'd136;
            SHA3_384: r = 8'd104;
            SHA3_512: r = 8'd72;
            SHAKE128: r = 8'd168;
            default:  r = 8'd136;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] digest_bytes(input mode_t m);
        logic [7:0] r;
        case (m)
            SHA3_224: r = 8'd28;
            SHA3_256: r = 8'd32;
            SHA3_384: r = 8'd48;
            SHA3_512: r = 8'd64;
            default:  r = 8'd0;
        endcase
        return r;
    endfunction

    function automatic logic is_shake(input mode_t m);
        return (m == SHAKE128) || (m == SHAKE256);
    endfunction

endpackage

// File: rtl/keccak_rate_mux.sv
// Picks one stream-width slice of the rate for a beat index and zeroes the
// byte lanes beyond the remaining digest length.
module keccak_rate_mux
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 16,
    localparam int KEEP_W    = DATA_WIDTH / 8
) (
    input  logic [STATE_W-1:0]    state,
    input  logic [7:0]            beat,
    input  logic [LEN_W-1:0]      rem,
    output logic [DATA_WIDTH-1:0] data,
    output logic [KEEP_W-1:0]     keep
);

    localparam int KSH = $clog2(KEEP_W);

    logic [10:0]           bit_off;
    logic [DATA_WIDTH-1:0] raw;

    always_comb begin
        bit_off = 11'(beat) << (KSH + 3);
        raw     = state[bit_off +: DATA_WIDTH];
        keep    = '0;
        data    = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            keep[i]        = rem > LEN_W'(i);
            data[8*i +: 8] = keep[i] ? raw[8*i +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/keccak_squeeze_stream.sv
// Streams the Keccak digest over AXI-Stream, requesting extra permutations
// when a SHAKE output runs past the rate.
module keccak_squeeze_stream
    import sha3_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_W      = 16,
    localparam int KEEP_W    = DATA_WIDTH / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [STATE_W-1:0]    state_in,
    input  logic                  state_valid,
    output logic                  state_ready,
    input  logic [2:0]            mode,
    input  logic [LEN_W-1:0]      out_len,
    output logic                  perm_req,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [KEEP_W-1:0]     M_AXIS_TKEEP,
    output logic                  M_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_PERM} fsm_t;

    localparam int               KSH    = $clog2(KEEP_W);
    localparam logic [LEN_W-1:0] KEEP_L = LEN_W'(KEEP_W);

    fsm_t                  fsm_q, fsm_d;
    logic [STATE_W-1:0]    st_q, st_d;
    mode_t                 mode_q, mode_d, new_mode;
    logic [LEN_W-1:0]      rem_q, rem_d, take;
    logic [7:0]            beat_q, beat_d;
    logic [10:0]           next_off;
    logic                  hs, accept;
    logic                  tvalid_d, done_d, perm_d, ready_d;
    logic [DATA_WIDTH-1:0] mux_data;
    logic [KEEP_W-1:0]     mux_keep;

    assign hs       = M_AXIS_TVALID && M_AXIS_TREADY;
    assign accept   = state_valid && state_ready;
    assign new_mode = decode_mode(mode);
    assign take     = (rem_q < KEEP_L) ? rem_q : KEEP_L;
    assign next_off = (11'(beat_q) + 11'd1) << KSH;

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        mode_d = mode_q;
        rem_d  = rem_q;
        beat_d = beat_q;
        done_d = 1'b0;
        perm_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    st_d   = state_in;
                    mode_d = new_mode;
                    beat_d = '0;
                    rem_d  = is_shake(new_mode) ? out_len
                                                : LEN_W'(digest_bytes(new_mode));
                    if (rem_d == '0) done_d = 1'b1;
                    else             fsm_d  = STREAM;
                end
            end
            STREAM: begin
                if (hs) begin
                    rem_d  = rem_q - take;
                    beat_d = beat_q + 8'd1;
                    if (M_AXIS_TLAST) begin
                        done_d = 1'b1;
                        fsm_d  = IDLE;
                    end else if (next_off == 11'(rate_bytes(mode_q))) begin
                        perm_d = 1'b1;
                        fsm_d  = WAIT_PERM;
                    end
                end
            end
            WAIT_PERM: begin
                if (accept) begin
                    st_d   = state_in;
                    beat_d = '0;
                    fsm_d  = STREAM;
                end
            end
            default: fsm_d = IDLE;
        endcase
        tvalid_d = (fsm_d == STREAM);
        // Ready drops for the done cycle so a new state lands only after it.
        ready_d  = (fsm_d != STREAM) && !done_d;
    end

    // The mux looks at next-cycle values so the output register stage adds
    // no extra latency beyond the single acceptance cycle.
    keccak_rate_mux #(
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_W     (LEN_W)
    ) u_rate_mux (
        .state(st_d),
        .beat (beat_d),
        .rem  (rem_d),
        .data (mux_data),
        .keep (mux_keep)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            fsm_q         <= IDLE;
            st_q          <= '0;
            mode_q        <= SHA3_224;
            rem_q         <= '0;
            beat_q        <= '0;
            state_ready   <= 1'b0;
            perm_req      <= 1'b0;
            done          <= 1'b0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TKEEP  <= '0;
            M_AXIS_TDATA  <= '0;
        end else begin
            fsm_q         <= fsm_d;
            st_q          <= st_d;
            mode_q        <= mode_d;
            rem_q         <= rem_d;
            beat_q        <= beat_d;
            state_ready   <= ready_d;
            perm_req      <= perm_d;
            done          <= done_d;
            M_AXIS_TVALID <= tvalid_d;
            M_AXIS_TLAST  <= tvalid_d && (rem_d <= KEEP_L);
            M_AXIS_TKEEP  <= tvalid_d ? mux_keep : '0;
            M_AXIS_TDATA  <= tvalid_d ? mux_data : '0;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_stream.sv
// Directed bench for the squeeze stage at 16, 32 and 64-bit stream widths.
module tb_keccak_squeeze_stream;
    import sha3_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1599:0] st;
    logic          sv;
    logic [2:0]    mode;
    logic [15:0]   out_len;
    logic          tready;
    int            sel;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    logic sv16, sv32, sv64;
    assign sv16 = sv && (sel == 16);
    assign sv32 = sv && (sel == 32);
    assign sv64 = sv && (sel == 64);

    logic        rdy16, rdy32, rdy64, pr16, pr32, pr64, dn16, dn32, dn64;
    logic        tl16, tl32, tl64, tv16, tv32, tv64;
    logic [15:0] td16;
    logic [31:0] td32;
    logic [63:0] td64;
    logic [1:0]  tk16;
    logic [3:0]  tk32;
    logic [7:0]  tk64;

    keccak_squeeze_stream #(.DATA_WIDTH(16), .LEN_W(16)) dut16 (
        .ACLK(clk), .ARESETn(rst_n), .state_in(st), .state_valid(sv16),
        .state_ready(rdy16), .mode(mode), .out_len(out_len), .perm_req(pr16),
        .M_AXIS_TDATA(td16), .M_AXIS_TKEEP(tk16), .M_AXIS_TLAST(tl16),
        .M_AXIS_TVALID(tv16), .M_AXIS_TREADY(tready), .done(dn16));
    keccak_squeeze_stream #(.DATA_WIDTH(32), .LEN_W(16)) dut32 (
        .ACLK(clk), .ARESETn(rst_n), .state_in(st), .state_valid(sv32),
        .state_ready(rdy32), .mode(mode), .out_len(out_len), .perm_req(pr32),
        .M_AXIS_TDATA(td32), .M_AXIS_TKEEP(tk32), .M_AXIS_TLAST(tl32),
        .M_AXIS_TVALID(tv32), .M_AXIS_TREADY(tready), .done(dn32));
    keccak_squeeze_stream #(.DATA_WIDTH(64), .LEN_W(16)) dut64 (
        .ACLK(clk), .ARESETn(rst_n), .state_in(st), .state_valid(sv64),
        .state_ready(rdy64), .mode(mode), .out_len(out_len), .perm_req(pr64),
        .M_AXIS_TDATA(td64), .M_AXIS_TKEEP(tk64), .M_AXIS_TLAST(tl64),
        .M_AXIS_TVALID(tv64), .M_AXIS_TREADY(tready), .done(dn64));

    logic [63:0] o_data;
    logic [7:0]  o_keep;
    logic        o_last, o_valid, o_ready, o_perm, o_done;

    always_comb begin
        o_data = {48'd0, td16}; o_keep = {6'd0, tk16}; o_last = tl16;
        o_valid = tv16; o_ready = rdy16; o_perm = pr16; o_done = dn16;
        if (sel == 32) begin
            o_data = {32'd0, td32}; o_keep = {4'd0, tk32}; o_last = tl32;
            o_valid = tv32; o_ready = rdy32; o_perm = pr32; o_done = dn32;
        end else if (sel == 64) begin
            o_data = td64; o_keep = tk64; o_last = tl64;
            o_valid = tv64; o_ready = rdy64; o_perm = pr64; o_done = dn64;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1599:0] mk_state(input int seed);
        logic [1599:0] s;
        for (int k = 0; k < 200; k++) s[8*k +: 8] = 8'((k + seed) & 255);
        return s;
    endfunction

    // Present a state; returns at the negedge just after acceptance.
    task automatic load(input logic [2:0] m, input int len, input int seed);
        int i;
        st = mk_state(seed); mode = m; out_len = 16'(len);
        for (i = 0; i < 50 && !o_ready; i++) @(negedge clk);
        chk("load_ready", o_ready, 1'b1);
        sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
    endtask

    // pat 0: TREADY always high; pat 1: toggling with a 7-cycle low stall.
    task automatic run_stream(input int len, input int rate, input int seed_a,
                              input int seed_b, input int pat,
                              output int nbeats, output int perms,
                              output logic [63:0] first_d, output logic [63:0] last_d,
                              output logic [7:0] last_k);
        int kw, got, rb, seed, cyc;
        bit rdy, stalled;
        logic [63:0] exp_d, held_d;
        logic [7:0]  exp_k, held_k;
        logic        held_l;
        kw = sel / 8; got = 0; rb = 0; seed = seed_a; stalled = 0;
        nbeats = 0; perms = 0; first_d = '0; last_d = '0; last_k = '0;
        held_d = '0; held_k = '0; held_l = 1'b0;
        chk("first_valid", o_valid, 1'b1);
        for (cyc = 0; cyc < 3000 && got < len; cyc++) begin
            if (o_perm) begin
                perms++;
                chk("perm_tvalid", o_valid, 1'b0);
                chk("perm_pos", rb, rate);
                repeat (5) @(negedge clk);
                chk("wait_tvalid", o_valid, 1'b0);
                load(mode, len, seed_b);
                seed = seed_b; rb = 0; stalled = 0;
                chk("resume_valid", o_valid, 1'b1);
                continue;
            end
            if (stalled) begin
                chk("hold_data", o_data, held_d);
                chk("hold_keep", o_keep, held_k);
                chk("hold_last", o_last, held_l);
            end
            rdy = (pat == 0) ? 1'b1 : ((cyc >= 10 && cyc < 17) ? 1'b0 : (cyc % 2 == 0));
            tready = rdy;
            if (o_valid) begin
                exp_d = '0; exp_k = '0;
                for (int i = 0; i < kw; i++)
                    if (got + i < len) begin
                        exp_d[8*i +: 8] = 8'((rb + i + seed) & 255);
                        exp_k[i] = 1'b1;
                    end
                chk("tdata", o_data, exp_d);
                chk("tkeep", o_keep, exp_k);
                chk("tlast", o_last, (len - got) <= kw);
                if (rdy) begin
                    if (nbeats == 0) first_d = o_data;
                    last_d = o_data; last_k = o_keep;
                    got += (len - got < kw) ? len - got : kw;
                    rb += kw; nbeats++; stalled = 0;
                end else begin
                    stalled = 1; held_d = o_data; held_k = o_keep; held_l = o_last;
                end
            end
            @(negedge clk);
        end
        chk("bytes_out", got, len);
        chk("done_pulse", o_done, 1'b1);
        chk("end_tvalid", o_valid, 1'b0);
        @(negedge clk);
        chk("done_clear", o_done, 1'b0);
        chk("ready_back", o_ready, 1'b1);
    endtask

    int nb, np;
    logic [63:0] fd, ld;
    logic [7:0]  lk;

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; sv = 1'b0; tready = 1'b0; mode = 3'd0; out_len = '0;
        st = '0; sel = 16;
        repeat (2) @(negedge clk);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_data", o_data, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", o_ready, 1'b1);

        // 1: 16-bit SHA3-256
        tready = 1'b1; sel = 16;
        load(3'd1, 0, 0);
        run_stream(32, 136, 0, 0, 0, nb, np, fd, ld, lk);
        chk("t1_beats", nb, 16);
        chk("t1_first", fd, 64'h0100);
        chk("t1_last", ld, 64'h1F1E);
        chk("t1_keep", lk, 8'h03);

        // 2: 64-bit SHA3-224, then mode 7 as SHA3-256
        sel = 64;
        load(3'd0, 0, 0);
        run_stream(28, 144, 0, 0, 0, nb, np, fd, ld, lk);
        chk("t2_beats", nb, 4);
        chk("t2_last", ld, 64'h0000_0000_1B1A_1918);
        chk("t2_keep", lk, 8'h0F);
        load(3'd7, 0, 0);
        run_stream(32, 136, 0, 0, 0, nb, np, fd, ld, lk);
        chk("t2b_beats", nb, 4);
        chk("t2b_keep", lk, 8'hFF);
        chk("t2b_last", ld, 64'h1F1E_1D1C_1B1A_1918);

        // 3: 64-bit SHAKE128, 200 bytes across a permutation
        load(3'd4, 200, 0);
        run_stream(200, 168, 0, 8'h40, 0, nb, np, fd, ld, lk);
        chk("t3_beats", nb, 25);
        chk("t3_perms", np, 1);
        chk("t3_last", ld, 64'h5F5E_5D5C_5B5A_5958);
        chk("t3_keep", lk, 8'hFF);

        // 4: 32-bit SHA3-512 under backpressure
        sel = 32;
        load(3'd3, 0, 3);
        run_stream(64, 72, 3, 3, 1, nb, np, fd, ld, lk);
        chk("t4_beats", nb, 16);
        chk("t4_first", fd, 64'h0605_0403);
        chk("t4_last", ld, 64'h4241_403F);
        tready = 1'b1;

        // 5: SHAKE256 zero length, then 5 bytes at 16 bits
        sel = 16;
        load(3'd5, 0, 0);
        chk("t5_novalid", o_valid, 1'b0);
        chk("t5_done", o_done, 1'b1);
        @(negedge clk);
        chk("t5_done_clr", o_done, 1'b0);
        load(3'd5, 5, 0);
        run_stream(5, 136, 0, 0, 0, nb, np, fd, ld, lk);
        chk("t5_beats", nb, 3);
        chk("t5_last", ld, 64'h0004);
        chk("t5_keep", lk, 8'h01);

        // 6: reset during a SHA3-384 stream, then a fresh SHA3-256
        load(3'd2, 0, 0);
        repeat (6) @(negedge clk);
        chk("t6_midstream", o_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", o_valid, 1'b0);
        chk("t6_data", o_data, 64'h0);
        chk("t6_keep", o_keep, 8'h0);
        chk("t6_last", o_last, 1'b0);
        chk("t6_ready", o_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_ready_after", o_ready, 1'b1);
        chk("t6_idle", o_valid, 1'b0);
        load(3'd1, 0, 8'h11);
        run_stream(32, 136, 8'h11, 8'h11, 0, nb, np, fd, ld, lk);
        chk("t6_beats", nb, 16);
        chk("t6_first", fd, 64'h1211);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keccak_squeeze_stream.md
Name: keccak_squeeze_stream

Overview:
Parametrised output stage for the SHA-3/SHAKE core. It takes the 1600-bit Keccak state after a permutation and streams the digest over an AXI-Stream master with full TREADY backpressure and TKEEP on a partial final beat. It supports all four SHA3 digests and SHAKE128/256 with arbitrary output length. When the rate is exhausted it requests further permutations from the round core.

Parameters:
DATA_WIDTH, 16, stream width in bits; legal values are 8, 16, 32 or 64.
LEN_W, 16, width of the SHAKE output-length field in bytes.
KEEP_W, DATA_WIDTH/8, derived; not user-set.

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
state_in  in  1600  Keccak state; lane (x,y) at bits [64*(x+5y)+63 : 64*(x+5y)]
state_valid  in  1  state_in valid from the round core
state_ready  out  1  block accepts state_in
mode  in  3  0 SHA3-224, 1 SHA3-256, 2 SHA3-384, 3 SHA3-512, 4 SHAKE128, 5 SHAKE256; 6-7 are treated as 1
out_len  in  LEN_W  SHAKE output bytes; ignored for SHA3 modes
perm_req  out  1  one-cycle pulse requesting another permutation (SHAKE only)
M_AXIS_TDATA  out  DATA_WIDTH  digest data
M_AXIS_TKEEP  out  KEEP_W  valid byte lanes
M_AXIS_TLAST  out  1  final beat of the digest
M_AXIS_TVALID  out  1  beat valid
M_AXIS_TREADY  in  1  downstream ready
done  out  1  one-cycle pulse after the final handshake

Behaviour:
- Reset: ARESETn low puts the FSM in IDLE asynchronously. state_ready=0, perm_req=0, TVALID=0, TLAST=0, TKEEP=0, TDATA=0, done=0, all counters 0. Reset mid-stream abandons the digest with no TLAST.
- FSM states: IDLE, STREAM, WAIT_PERM.
- IDLE: state_ready=1.
  - On state_valid&&state_ready, latch state_in, mode and out_len.
  - rem_bytes is set to 28, 32, 48 or 64 for SHA3, or to out_len for SHAKE.
  - beat index is set to 0, then go to STREAM.
  - mode and out_len are sampled only at this acceptance.
- Rate in bytes: 144, 136, 104, 72 for SHA3-224/256/384/512; 168 for SHAKE128; 136 for SHAKE256.
- Byte order: Keccak standard. Byte k of the rate is bits [8k+7:8k] of the latched state, i.e. little-endian within each lane, lanes in index order. Beat n carries rate bytes n*KEEP_W .. n*KEEP_W+KEEP_W-1, with the lowest byte in TDATA[7:0]. No byte reversal.
- STREAM:
  - TVALID=1 starting the cycle after acceptance (1-cycle latency).
  - TKEEP low bits set for min(rem_bytes, KEEP_W); unused TDATA bytes are 0.
  - TLAST=1 iff rem_bytes <= KEEP_W.
  - While TVALID&&!TREADY, TDATA, TKEEP and TLAST hold stable.
  - On each handshake: rem_bytes -= min(rem_bytes, KEEP_W), beat index +1.
  - If the handshake was on TLAST: done=1 for one cycle, go to IDLE; state_ready rises the following cycle.
  - Else if beat index*KEEP_W reaches the rate (SHAKE only; SHA3 digests never exceed the rate): perm_req=1 for one cycle, TVALID=0, go to WAIT_PERM.
- WAIT_PERM: state_ready=1.
  - On state_valid, latch the new state, reset beat index to 0, keep rem_bytes, return to STREAM with 1-cycle latency.
  - state_valid in STREAM is ignored (state_ready=0).
- All rates are multiples of 8 bytes, so a beat never straddles a rate boundary for any legal DATA_WIDTH.
- SHAKE with out_len=0: the state is accepted, no beat is emitted, done pulses the cycle after acceptance, return to IDLE.
- Simultaneous final handshake and state_valid: the state is not accepted that cycle, because state_ready is registered and 0 in STREAM.
- All outputs are registered. One beat per cycle is sustained under continuous TREADY.

Decomposition:
- Package sha3_pkg:
  - mode_t enum (SHA3_224..SHAKE256).
  - Rate-bytes and digest-bytes lookup functions indexed by mode_t.
  - STATE_W=1600 and LANE_W=64.
- One natural sub-module: keccak_rate_mux. It is combinational: selects the DATA_WIDTH slice of the latched state for a beat index and applies the TKEEP zero-mask.
- The FSM, counters and AXI register stage stay in the top module.

Test Plan:
1. DATA_WIDTH=16, SHA3-256, state bytes = byte index mod 256, TREADY=1. Expect: 16 beats, TDATA 0x0100, 0x0302, …, 0x1F1E; TKEEP=2'b11 throughout; TLAST on beat 16; done one cycle later.
2. DATA_WIDTH=64, SHA3-224. Expect: 4 beats; beat 4 TKEEP=8'h0F, TDATA[63:32]=0, TLAST=1. Then mode=7 yields the SHA3-256 result, 4 beats with TKEEP=8'hFF.
3. DATA_WIDTH=64, SHAKE128, out_len=200.
   - Expect 21 beats, then a perm_req pulse and TVALID=0.
   - Supply a second state after 5 cycles. Expect 4 more beats (32 bytes), TLAST on beat 25, all TKEEP=8'hFF.
   - Byte 168 equals byte 0 of the second state.
4. DATA_WIDTH=32, SHA3-512, TREADY toggling 1010… and held low for 7 cycles mid-stream. Expect: TDATA/TKEEP/TLAST stable while stalled, 16 beats total, no dropped or duplicated word.
5. SHAKE256, out_len=0 -> no TVALID, done one cycle after acceptance. Also: SHAKE256, out_len=5, DATA_WIDTH=16 -> 3 beats, TKEEP 11, 11, 01, TLAST on the third.
6. ARESETn low for 1 cycle during beat 6 of a SHA3-384 stream. Expect: all outputs 0 asynchronously, FSM in IDLE, state_ready=1 after release. A new SHA3-256 digest then streams correctly from beat 0.
